fifo_batch_ctrl: RTL and testbench



---
 rtl/fifo_batch_ctrl_pkg.sv | 12 +
 rtl/fifo_batch_ctrl_fifo2.sv | 74 +++++++
 rtl/fifo_batch_ctrl.sv | 107 ++++++++++
 tb/tb_fifo_batch_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_batch_ctrl_pkg.sv
// Shared definitions for the batch sequencer: state encoding and producer indices.
package fifo_batch_ctrl_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic PROD_0 = 1'b0;
    localparam logic PROD_1 = 1'b1;

endpackage

// File: rtl/fifo_batch_ctrl_fifo2.sv
// Circular-buffer FIFO with registered full/empty flags and registered read data.
module fifo2 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_en,
    output logic [WIDTH-1:0] read_data,
    output logic             full,
    output logic             empty,
    output logic             almost_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic [OCC_W-1:0] count_next;
    logic             do_write;
    logic             do_read;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign do_write     = write_en && !full;
    assign do_read      = read_en && !empty;
    assign almost_empty = (count == OCC_W'(1));

    always_comb begin
        count_next = count;
        if (do_write && !do_read) begin
            count_next = count + OCC_W'(1);
        end else if (do_read && !do_write) begin
            count_next = count - OCC_W'(1);
        end
    end

    // Storage needs no reset; occupancy tracking guards every read.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            read_data <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_read) begin
                rd_ptr    <= next_ptr(rd_ptr);
                read_data <= mem[rd_ptr];
            end
            count <= count_next;
            full  <= (count_next == OCC_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/fifo_batch_ctrl.sv
// Batch sequencer: round-robin fill of one FIFO from two producers, then a full drain.
import fifo_batch_ctrl_pkg::*;

module fifo_batch_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_valid,
    input  logic [WIDTH-1:0] p0_data,
    output logic             p0_ready,
    input  logic             p1_valid,
    input  logic [WIDTH-1:0] p1_data,
    output logic             p1_ready,
    input  logic             flush_req,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             filling,
    output logic [CNT_W-1:0] batch_count
);

    state_t           state;
    state_t           state_next;
    logic             rr_pref;
    logic             grant;
    logic             eligible;
    logic             write_en;
    logic [WIDTH-1:0] write_data;
    logic             read_en;
    logic [WIDTH-1:0] read_data;
    logic             full;
    logic             empty;
    logic             almost_empty;
    logic             drain_done;

    fifo2 #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .write_en    (write_en),
        .write_data  (write_data),
        .read_en     (read_en),
        .read_data   (read_data),
        .full        (full),
        .empty       (empty),
        .almost_empty(almost_empty)
    );

    // The drain ends on the edge that removes the last word, so the final
    // out_valid pulse lands in the first FILL cycle.
    always_comb begin
        grant = rr_pref;
        if (p0_valid && !p1_valid) begin
            grant = PROD_0;
        end else if (p1_valid && !p0_valid) begin
            grant = PROD_1;
        end
        eligible   = (state == ST_FILL) && !full && !reset;
        p0_ready   = eligible && (grant == PROD_0);
        p1_ready   = eligible && (grant == PROD_1);
        write_en   = (p0_ready && p0_valid) || (p1_ready && p1_valid);
        write_data = (grant == PROD_1) ? p1_data : p0_data;
        read_en    = (state == ST_DRAIN) && !empty;
        drain_done = (state == ST_DRAIN) && (empty || almost_empty);

        state_next = state;
        case (state)
            ST_FILL: begin
                if (full || (flush_req && !empty)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_next = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FILL;
            rr_pref     <= PROD_0;
            out_valid   <= 1'b0;
            batch_count <= '0;
        end else begin
            state     <= state_next;
            out_valid <= read_en;
            if (write_en) begin
                rr_pref <= ~grant;
            end
            if (drain_done) begin
                batch_count <= batch_count + CNT_W'(1);
            end
        end
    end

    assign filling  = (state == ST_FILL);
    assign out_data = read_data;

endmodule

// File: tb/tb_fifo_batch_ctrl.sv
// Self-checking bench: vector table, directed sequences and random traffic against a queue model.
module tb_fifo_batch_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p0_valid = 1'b0;
    logic [7:0] p0_data = 8'h00;
    logic       p0_ready;
    logic       p1_valid = 1'b0;
    logic [7:0] p1_data = 8'h00;
    logic       p1_ready;
    logic       flush_req = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       filling;
    logic [7:0] batch_count;

    fifo_batch_ctrl #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .p0_valid   (p0_valid),
        .p0_data    (p0_data),
        .p0_ready   (p0_ready),
        .p1_valid   (p1_valid),
        .p1_data    (p1_data),
        .p1_ready   (p1_ready),
        .flush_req  (flush_req),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .filling    (filling),
        .batch_count(batch_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: FIFO as a queue, plus mode, tie-break preference and output register.
    logic [7:0] m_q[$];
    logic       m_fill = 1'b1;
    logic       m_pref = 1'b0;
    logic       m_outv = 1'b0;
    logic [7:0] m_outd = 8'h00;
    logic [7:0] m_cnt = 8'h00;

    int         mode = 0;
    logic [7:0] p0_next = 8'h00;
    int         p0_left = 0;
    logic [7:0] p1_next = 8'h00;
    int         p1_left = 0;
    logic [7:0] seen[$];

    typedef struct {
        logic       rst;
        logic       p0v;
        logic [7:0] p0d;
        logic       p1v;
        logic [7:0] p1d;
        logic       fl;
        logic       e_p0r;
        logic       e_p1r;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_fill;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic modelGrant();
        if (p0_valid && !p1_valid) return 1'b0;
        if (p1_valid && !p0_valid) return 1'b1;
        return m_pref;
    endfunction

    task automatic checkOutput();
        logic elig;
        logic g;
        elig = m_fill && (m_q.size() < DEPTH) && !reset;
        g = modelGrant();
        if (!elig) begin
            check("p0_ready_idle", 32'(p0_ready), 32'd0);
            check("p1_ready_idle", 32'(p1_ready), 32'd0);
        end else if (p0_valid || p1_valid) begin
            check("p0_ready", 32'(p0_ready), 32'(g == 1'b0));
            check("p1_ready", 32'(p1_ready), 32'(g == 1'b1));
        end
        check("one_ready", 32'(p0_ready && p1_ready), 32'd0);
        check("out_valid", 32'(out_valid), 32'(m_outv));
        check("out_data", 32'(out_data), 32'(m_outd));
        check("filling", 32'(filling), 32'(m_fill));
        check("batch_count", 32'(batch_count), 32'(m_cnt));
        if (out_valid === 1'b1) seen.push_back(out_data);
    endtask

    task automatic modelStep();
        int   sz;
        logic g;
        if (reset) begin
            m_q.delete();
            m_fill = 1'b1;
            m_pref = 1'b0;
            m_outv = 1'b0;
            m_outd = 8'h00;
            m_cnt  = 8'h00;
        end else if (m_fill) begin
            sz = m_q.size();
            if (sz < DEPTH && (p0_valid || p1_valid)) begin
                g = modelGrant();
                m_q.push_back(g ? p1_data : p0_data);
                m_pref = !g;
                if (mode == 0) begin
                    if (g) begin p1_next++; p1_left--; end
                    else begin p0_next++; p0_left--; end
                end
            end
            m_outv = 1'b0;
            if (sz == DEPTH || (flush_req && sz > 0)) m_fill = 1'b0;
        end else begin
            if (m_q.size() > 0) begin
                m_outd = m_q.pop_front();
                m_outv = 1'b1;
                if (m_q.size() == 0) begin
                    m_fill = 1'b1;
                    m_cnt++;
                end
            end else begin
                m_outv = 1'b0;
                m_fill = 1'b1;
                m_cnt++;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic fl);
        @(negedge clk);
        reset = r;
        flush_req = fl;
        if (mode == 1) begin
            p0_valid = ($urandom_range(0, 3) != 0);
            p0_data  = 8'($urandom);
            p1_valid = ($urandom_range(0, 3) != 0);
            p1_data  = 8'($urandom);
        end else begin
            p0_valid = (p0_left > 0);
            p0_data  = p0_next;
            p1_valid = (p1_left > 0);
            p1_data  = p1_next;
        end
        #1;
    endtask

    task automatic runCycle(input logic r, input logic fl);
        applyStimulus(r, fl);
        checkOutput();
        @(posedge clk);
        modelStep();
    endtask

    initial begin
        logic       hit;
        logic [7:0] exp_word;

        tbl[0]  = '{1'b1, 1'b1, 8'hA0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 8'hA3, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB0, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 8'h01};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01};

        repeat (2) begin
            @(posedge clk);
            modelStep();
        end

        mode = 2;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            reset     = tbl[i].rst;
            p0_valid  = tbl[i].p0v;
            p0_data   = tbl[i].p0d;
            p1_valid  = tbl[i].p1v;
            p1_data   = tbl[i].p1d;
            flush_req = tbl[i].fl;
            #1;
            check($sformatf("tbl%0d_p0_ready", i), 32'(p0_ready), 32'(tbl[i].e_p0r));
            check($sformatf("tbl%0d_p1_ready", i), 32'(p1_ready), 32'(tbl[i].e_p1r));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            check($sformatf("tbl%0d_filling", i), 32'(filling), 32'(tbl[i].e_fill));
            check($sformatf("tbl%0d_batch_count", i), 32'(batch_count), 32'(tbl[i].e_cnt));
            checkOutput();
            @(posedge clk);
            modelStep();
        end
        mode = 0;

        // Single producer, one full batch.
        p0_left = 0; p1_left = 0;
        runCycle(1'b1, 1'b0);
        seen.delete();
        p0_next = 8'h00; p0_left = 8;
        repeat (20) runCycle(1'b0, 1'b0);
        check("s1_batch_count", 32'(batch_count), 32'd1);
        check("s1_words", 32'(seen.size()), 32'd8);

        // Both producers: alternating acceptance order, two batches.
        runCycle(1'b1, 1'b0);
        seen.delete();
        p0_next = 8'h10; p0_left = 8;
        p1_next = 8'h20; p1_left = 8;
        repeat (45) runCycle(1'b0, 1'b0);
        check("s2_words", 32'(seen.size()), 32'd16);
        for (int i = 0; i < 8 && i < seen.size(); i++) begin
            exp_word = ((i % 2) == 0) ? 8'(8'h10 + i / 2) : 8'(8'h20 + i / 2);
            check($sformatf("s2_order%0d", i), 32'(seen[i]), 32'(exp_word));
        end

        // Partial batch closed by a one-cycle flush.
        runCycle(1'b1, 1'b0);
        seen.delete();
        p0_next = 8'hA0; p0_left = 3;
        repeat (4) runCycle(1'b0, 1'b0);
        runCycle(1'b0, 1'b1);
        repeat (8) runCycle(1'b0, 1'b0);
        check("s3_batch_count", 32'(batch_count), 32'd1);
        check("s3_words", 32'(seen.size()), 32'd3);

        // Flush on an empty FIFO is ignored.
        repeat (3) runCycle(1'b0, 1'b1);
        check("s4_filling", 32'(filling), 32'd1);
        check("s4_batch_count", 32'(batch_count), 32'd1);
        check("s4_words", 32'(seen.size()), 32'd3);

        // Producers held valid through a drain.
        p0_next = 8'h60; p0_left = 10;
        p1_next = 8'h70; p1_left = 3;
        repeat (40) runCycle(1'b0, 1'b0);
        check("s5_all_accepted", 32'(p0_left + p1_left), 32'd0);

        // Reset while the fourth drained word is on the output.
        runCycle(1'b1, 1'b0);
        p0_next = 8'h40; p0_left = 8;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (m_outv && m_outd == 8'h43) begin
                runCycle(1'b1, 1'b0);
                hit = 1'b1;
            end else begin
                runCycle(1'b0, 1'b0);
            end
        end
        check("s6_reset_applied", 32'(hit), 32'd1);
        #2;
        check("s6_out_valid", 32'(out_valid), 32'd0);
        check("s6_filling", 32'(filling), 32'd1);
        check("s6_batch_count", 32'(batch_count), 32'd0);
        seen.delete();
        p0_next = 8'h50; p0_left = 8;
        repeat (22) runCycle(1'b0, 1'b0);
        check("s6_refill_words", 32'(seen.size()), 32'd8);
        if (seen.size() > 0) check("s6_first_word", 32'(seen[0]), 32'h50);

        // Random traffic against the model.
        mode = 1;
        repeat (400) runCycle($urandom_range(0, 149) == 0, $urandom_range(0, 19) == 0);
        mode = 0;
        p0_left = 0; p1_left = 0;
        repeat (12) runCycle(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
